// File: rtl/aes_pkg.sv
// Shared definitions for the AES encrypt-core arbiter: the 128-bit block type,
// the default core latency and the tag-width helper.
package aes_pkg;

  typedef logic [127:0] block_t;

  // AES-128 core: Nr (10) rounds plus input and output register stages.
  localparam int DEFAULT_LAT = 12;

  // Tag width needed to name one of n requesters, never less than one bit.
  function automatic int tag_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aes_enc_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first requesting index at or after
// i_ptr, searching upward and wrapping from NREQ-1 to 0.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int TAGW = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [TAGW-1:0] i_ptr,
  output logic [NREQ-1:0] o_gnt
);

  logic [TAGW:0]   w_sum;
  logic [TAGW-1:0] w_idx;
  logic            w_found;

  // Walk the requesters in priority order starting at the pointer.
  always_comb begin
    // NOTE: every variable gets a default before the loop, so no path leaves
    // one unassigned and no latch is inferred.
    o_gnt   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, i_ptr} + (TAGW+1)'(i);
      if (w_sum >= (TAGW+1)'(NREQ)) w_sum = w_sum - (TAGW+1)'(NREQ);
      w_idx = w_sum[TAGW-1:0];
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_enc_arbiter.sv
// Arbiter sharing one pipelined AES encrypt core between NREQ requesters.
// A LAT-deep tag line travels alongside the core so each ciphertext returns
// to the requester that issued it; err latches any core/tag misalignment.
// Optional build macro AES_ARB_STATS_EN adds per-requester saturating 16-bit
// grant counters on stat_cnt.
module aes_enc_arbiter
  import aes_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = DEFAULT_LAT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [NREQ-1:0]   req_vld,
  output logic [NREQ-1:0]   req_rdy,
  input  logic [128*NREQ-1:0] req_data,
  input  logic [128*NREQ-1:0] req_key,
  output logic              c_vld,
  output block_t            c_in,
  output block_t            c_key,
  input  logic              c_ovld,
  input  block_t            c_out,
  output logic [NREQ-1:0]   rsp_vld,
  output block_t            rsp_data,
  output logic              err
`ifdef AES_ARB_STATS_EN
  ,
  output logic [16*NREQ-1:0] stat_cnt
`endif
);

  localparam int TAGW = tag_width(NREQ);

  typedef struct packed {
    logic            vld;
    logic [TAGW-1:0] tag;
  } dl_ent_t;

  logic [NREQ-1:0] w_req;
  logic [NREQ-1:0] w_gnt;
  logic            w_gnt_any;
  logic [TAGW-1:0] w_gnt_idx;
  block_t          w_sel_data;
  block_t          w_sel_key;
  dl_ent_t         w_dl_out;

  logic [TAGW-1:0] r_ptr;
  logic            r_c_vld;
  block_t          r_c_in;
  block_t          r_c_key;
  logic [TAGW-1:0] r_tag;
  dl_ent_t         r_dl [LAT];
  logic [NREQ-1:0] r_rsp_vld;
  block_t          r_rsp_data;
  logic            r_err;

  // Requests are invisible while disabled or in reset, so no grant can occur.
  assign w_req = (i_en && !i_rst) ? req_vld : '0;

  rr_arbiter #(
    .NREQ (NREQ),
    .TAGW (TAGW)
  ) u_rr (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  assign req_rdy   = w_gnt;
  assign w_gnt_any = |w_gnt;

  // Encode the one-hot grant and select the winner's plaintext and key.
  always_comb begin
    w_gnt_idx  = '0;
    w_sel_data = '0;
    w_sel_key  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_gnt[k]) begin
        w_gnt_idx  = TAGW'(k);
        w_sel_data = req_data[128*k +: 128];
        w_sel_key  = req_key[128*k +: 128];
      end
    end
  end

  // Issue stage: register the accepted block toward the core, advance pointer.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (i_rst) begin
      r_ptr   <= '0;
      r_c_vld <= 1'b0;
      r_c_in  <= '0;
      r_c_key <= '0;
      r_tag   <= '0;
    end else begin
      r_c_vld <= w_gnt_any;
      if (w_gnt_any) begin
        r_c_in  <= w_sel_data;
        r_c_key <= w_sel_key;
        r_tag   <= w_gnt_idx;
        r_ptr   <= (w_gnt_idx == TAGW'(NREQ-1)) ? '0 : w_gnt_idx + TAGW'(1);
      end
    end
  end

  // Tag line: follows c_vld through LAT stages to meet the matching c_ovld.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the line is a shift register of flops, not a RAM; its valid
      // bits must clear so blocks discarded by the core leave no stale tags.
      for (int i = 0; i < LAT; i++) r_dl[i] <= '0;
    end else begin
      r_dl[0] <= '{vld: r_c_vld, tag: r_tag};
      for (int i = 1; i < LAT; i++) r_dl[i] <= r_dl[i-1];
    end
  end

  assign w_dl_out = r_dl[LAT-1];

  // Return stage: route ciphertext to its owner and latch misalignment errors.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_vld  <= '0;
      r_rsp_data <= '0;
      r_err      <= 1'b0;
    end else begin
      r_rsp_vld <= '0;
      if (c_ovld && w_dl_out.vld) begin
        r_rsp_data <= c_out;
        for (int k = 0; k < NREQ; k++) begin
          if (w_dl_out.tag == TAGW'(k)) r_rsp_vld[k] <= 1'b1;
        end
      end
      if (c_ovld != w_dl_out.vld) r_err <= 1'b1;
    end
  end

  assign c_vld    = r_c_vld;
  assign c_in     = r_c_in;
  assign c_key    = r_c_key;
  assign rsp_vld  = r_rsp_vld;
  assign rsp_data = r_rsp_data;
  assign err      = r_err;

`ifdef AES_ARB_STATS_EN
  logic [15:0] r_stat [NREQ];

  // Per-requester grant counters that stick at 16'hFFFF.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NREQ; k++) r_stat[k] <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (w_gnt[k] && (r_stat[k] != 16'hFFFF)) r_stat[k] <= r_stat[k] + 16'd1;
      end
    end
  end

  // Pack the counters onto the flat output bus.
  always_comb begin
    stat_cnt = '0;
    for (int k = 0; k < NREQ; k++) stat_cnt[16*k +: 16] = r_stat[k];
  end
`endif

endmodule

// File: doc/aes_enc_arbiter.md
AES_ENC_ARBITER -- requirements
Module: aes_enc_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one pipelined AES encrypt core (2..8).
REQ-002 SHALL have parameter LAT, default 12: core latency in cycles, from c_vld to c_ovld (Nr+2 for AES-128).
REQ-003 SHALL have derived localparam TAGW = max(1, clog2(NREQ)): tag width.
REQ-004 SHALL have port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port i_en, input, 1: grant enable; 0 blocks new grants, in-flight blocks still complete.
REQ-007 SHALL have port req_vld, input, NREQ: per-requester request valid.
REQ-008 SHALL have port req_rdy, output, NREQ: per-requester accept; combinational, one-hot or zero.
REQ-009 SHALL have port req_data, input, 128*NREQ: plaintext; requester k occupies bits [128k+127:128k].
REQ-010 SHALL have port req_key, input, 128*NREQ: cipher key per requester, same packing.
REQ-011 SHALL have port c_vld, output, 1: core input valid (drives core i_vld).
REQ-012 SHALL have port c_in, output, 128: plaintext to core.
REQ-013 SHALL have port c_key, output, 128: key to core.
REQ-014 SHALL have port c_ovld, input, 1: core output valid.
REQ-015 SHALL have port c_out, input, 128: core ciphertext.
REQ-016 SHALL have port rsp_vld, output, NREQ: one-cycle pulse to the owning requester.
REQ-017 SHALL have port rsp_data, output, 128: ciphertext shared by all requesters; qualified by rsp_vld.
REQ-018 SHALL have port err, output, 1: sticky error flag.

Function
REQ-019 SHALL grant at most one requester per cycle, only when i_en=1, using round-robin starting from the index after the last granted requester.
REQ-020 SHALL treat a request as accepted in cycle t when req_vld[k]&req_rdy[k] = 1.
REQ-021 SHALL register the accepted data and key, asserting c_vld=1 with c_in/c_key in cycle t+1; c_vld=0 otherwise, and c_in/c_key hold their last values.
REQ-022 SHALL push {valid, tag=k} into a LAT-deep tag delay line aligned to c_vld, so the tag reaches the line output in the same cycle as the matching c_ovld.
REQ-023 SHALL, on c_ovld=1 with a valid tag k, register c_out into rsp_data and pulse rsp_vld[k]=1 in the next cycle (request accept to rsp_vld = LAT+2 cycles).
REQ-024 SHALL set err=1 when c_ovld=1 and the delay-line output is invalid, or when the output is valid and c_ovld=0; err is cleared only by reset.
REQ-025 SHALL sustain back-to-back grants: one grant per cycle at full load, each of N continuously requesting requesters served once every N cycles.
REQ-026 SHALL not update the round-robin pointer in cycles with no grant; the pointer wraps from NREQ-1 to 0.
REQ-027 SHALL complete in-flight blocks normally when i_en falls.

Reset
REQ-028 SHALL, with i_rst=1, clear req_rdy, c_vld, rsp_vld, err, all delay-line valids and the pointer (so requester 0 has first priority); c_in, c_key and rsp_data reset to 0.
REQ-029 SHALL discard blocks in flight at reset without raising err, because the core shares i_rst.

Configuration
REQ-030 SHALL, with AES_ARB_STATS_EN defined, provide an output stat_cnt, 16*NREQ, holding per-requester saturating 16-bit grant counters cleared by reset.
REQ-031 SHALL, without AES_ARB_STATS_EN, omit stat_cnt and its logic entirely.

Structure
REQ-032 SHALL define the 128-bit block type, the tag width function and the default LAT in shared package aes_pkg.
REQ-033 SHALL implement the round-robin grant in a sub-module rr_arbiter (inputs request vector and pointer, output one-hot grant).

Verification
REQ-034 SHALL cover: requester 2 alone, data 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> rsp_vld[2] at LAT+2 with 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-035 SHALL cover: all 4 requesting continuously for 40 cycles -> grant order 0,1,2,3,0,... and each requester gets exactly 10 grants.
REQ-036 SHALL cover: i_en=0 for 5 cycles mid-stream -> no grants, in-flight rsp_vld pulses still arrive, pointer resumes its order.
REQ-037 SHALL cover: i_rst for 1 cycle with 6 blocks in flight -> no rsp_vld afterwards, err=0, next grant goes to requester 0.
REQ-038 SHALL cover: a c_ovld pulse forced with an empty delay line -> err=1, staying 1 until reset.
REQ-039 SHALL cover, with AES_ARB_STATS_EN: 70000 grants to requester 1 -> stat_cnt[31:16]=FFFF (saturated).
